// File: rtl/i2s_pkg.sv
// Frame constants and the counter-derived receive state shared by the I2S receiver
// and transmitter.
package i2s_pkg;

    localparam int unsigned SAMPLE_BITS = 24;
    localparam int unsigned SLOT_BITS   = 32;
    localparam int unsigned FRAME_BITS  = 64;
    localparam int unsigned CNT_W       = $clog2(FRAME_BITS);
    localparam int unsigned CNT_IDLE    = FRAME_BITS - 1;

    typedef logic [CNT_W-1:0]       cnt_t;
    typedef logic [SAMPLE_BITS-1:0] sample_t;

    typedef enum logic [1:0] {
        StIdle,
        StLeft,
        StRight
    } rx_state_e;

    // The bit counter doubles as the state: saturated means idle.
    function automatic rx_state_e cnt_state(input cnt_t cnt);
        if (cnt == cnt_t'(CNT_IDLE)) begin
            return StIdle;
        end else if (cnt < cnt_t'(SLOT_BITS)) begin
            return StLeft;
        end
        return StRight;
    endfunction

endpackage

// File: rtl/i2s_pin_sync.sv
// Three-flop synchronizers for the I2S pins plus a registered bclk rising-edge strobe;
// lr and data are re-registered so they stay aligned with the strobe.
module i2s_pin_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bclk_i,
    input  logic lr_i,
    input  logic d_i,
    output logic bclk_rise_o,
    output logic lr_o,
    output logic d_o
);

    logic [2:0] bclk_sync_q;
    logic [2:0] lr_sync_q;
    logic [2:0] d_sync_q;
    logic       bclk_prev_q;
    logic       bclk_rise_q;
    logic       lr_q;
    logic       d_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            d_sync_q    <= '0;
            bclk_prev_q <= 1'b0;
            bclk_rise_q <= 1'b0;
            lr_q        <= 1'b0;
            d_q         <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[1:0], bclk_i};
            lr_sync_q   <= {lr_sync_q[1:0], lr_i};
            d_sync_q    <= {d_sync_q[1:0], d_i};
            bclk_prev_q <= bclk_sync_q[2];
            bclk_rise_q <= bclk_sync_q[2] & ~bclk_prev_q;
            lr_q        <= lr_sync_q[2];
            d_q         <= d_sync_q[2];
        end
    end

    assign bclk_rise_o = bclk_rise_q;
    assign lr_o        = lr_q;
    assign d_o         = d_q;

endmodule

// File: rtl/i2s_data_receiver.sv
// I2S receive deserialiser: 64-bit stereo frames to 24-bit left/right samples.
// Optional malformed-frame detection is built when I2S_RX_FRAME_CHECK_EN is defined.
module i2s_data_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_DELAY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i2s_bclk,
    input  logic                   i2s_lr,
    input  logic                   i2s_d_in,
    output logic [SAMPLE_BITS-1:0] audio_l_out,
    output logic [SAMPLE_BITS-1:0] audio_r_out,
    output logic                   new_sample,
    output logic                   frame_err
);

    localparam cnt_t LeftCap  = cnt_t'(DATA_DELAY + SAMPLE_BITS - 1);
    localparam cnt_t RightCap = cnt_t'(DATA_DELAY + SLOT_BITS + SAMPLE_BITS - 1);

    logic bclk_rise;
    logic lr_s;
    logic d_s;

    i2s_pin_sync u_pin_sync (
        .clk_i       (clk),
        .rst_i       (rst),
        .bclk_i      (i2s_bclk),
        .lr_i        (i2s_lr),
        .d_i         (i2s_d_in),
        .bclk_rise_o (bclk_rise),
        .lr_o        (lr_s),
        .d_o         (d_s)
    );

    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic                  lr_last_q, lr_last_d;
    cnt_t                  bit_cnt_q, bit_cnt_d;
    sample_t               left_hold_q, left_hold_d;
    sample_t               audio_l_q, audio_l_d;
    sample_t               audio_r_q, audio_r_d;
    logic                  new_sample_q, new_sample_d;
    logic                  boundary;

    always_comb begin
        sr_d         = sr_q;
        lr_last_d    = lr_last_q;
        bit_cnt_d    = bit_cnt_q;
        left_hold_d  = left_hold_q;
        audio_l_d    = audio_l_q;
        audio_r_d    = audio_r_q;
        new_sample_d = 1'b0;
        boundary     = 1'b0;
        if (bclk_rise) begin
            sr_d      = (sr_q << 1) | FRAME_BITS'(d_s);
            lr_last_d = lr_s;
            boundary  = lr_s & ~lr_last_q;
            if (boundary) begin
                bit_cnt_d = '0;
            end else if (bit_cnt_q != cnt_t'(CNT_IDLE)) begin
                bit_cnt_d = bit_cnt_q + cnt_t'(1);
            end
            // Captures fire only on the increment into the target, never while saturated.
            if (!boundary && cnt_state(bit_cnt_q) != StIdle) begin
                if (bit_cnt_d == LeftCap) begin
                    left_hold_d = sr_d[SAMPLE_BITS-1:0];
                end
                if (bit_cnt_d == RightCap) begin
                    audio_r_d    = sr_d[SAMPLE_BITS-1:0];
                    audio_l_d    = left_hold_q;
                    new_sample_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q         <= '0;
            lr_last_q    <= 1'b0;
            bit_cnt_q    <= cnt_t'(CNT_IDLE);
            left_hold_q  <= '0;
            audio_l_q    <= '0;
            audio_r_q    <= '0;
            new_sample_q <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            lr_last_q    <= lr_last_d;
            bit_cnt_q    <= bit_cnt_d;
            left_hold_q  <= left_hold_d;
            audio_l_q    <= audio_l_d;
            audio_r_q    <= audio_r_d;
            new_sample_q <= new_sample_d;
        end
    end

    assign audio_l_out = audio_l_q;
    assign audio_r_out = audio_r_q;
    assign new_sample  = new_sample_q;

`ifdef I2S_RX_FRAME_CHECK_EN
    logic right_done_q, right_done_d;
    logic frame_err_q, frame_err_d;

    always_comb begin
        right_done_d = right_done_q;
        frame_err_d  = 1'b0;
        if (bclk_rise) begin
            if (boundary) begin
                right_done_d = 1'b0;
                if (cnt_state(bit_cnt_q) != StIdle && !right_done_q) begin
                    frame_err_d = 1'b1;
                end
            end else if (new_sample_d) begin
                right_done_d = 1'b1;
            end
            // lr must fall exactly at the left/right slot boundary.
            if (lr_last_q && !lr_s && bit_cnt_q != cnt_t'(SLOT_BITS - 1)) begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            right_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            right_done_q <= right_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_data_receiver.sv
// Bench for i2s_data_receiver: three instances (DATA_DELAY 0, 1, 8) share bclk/lr and
// each gets its own data line generated from frame-level sample values.
module tb_i2s_data_receiver;

    typedef struct {
        int          cyc;
        logic [23:0] l;
        logic [23:0] r;
    } ev_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          nbits;
        int          rst_at;
        bit          vchk;
    } vec_t;

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        bclk;
    logic        lr;
    logic        d     [3];
    logic [23:0] aud_l [3];
    logic [23:0] aud_r [3];
    logic        ns    [3];
    logic        fe    [3];

    int dly [3] = '{0, 1, 8};

    always #5 clk = ~clk;

    i2s_data_receiver #(.DATA_DELAY(0)) u_dut0 (
        .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lr(lr), .i2s_d_in(d[0]),
        .audio_l_out(aud_l[0]), .audio_r_out(aud_r[0]), .new_sample(ns[0]), .frame_err(fe[0])
    );
    i2s_data_receiver #(.DATA_DELAY(1)) u_dut1 (
        .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lr(lr), .i2s_d_in(d[1]),
        .audio_l_out(aud_l[1]), .audio_r_out(aud_r[1]), .new_sample(ns[1]), .frame_err(fe[1])
    );
    i2s_data_receiver #(.DATA_DELAY(8)) u_dut8 (
        .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lr(lr), .i2s_d_in(d[2]),
        .audio_l_out(aud_l[2]), .audio_r_out(aud_r[2]), .new_sample(ns[2]), .frame_err(fe[2])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every new_sample pulse and frame_err pulse, sampled mid-cycle.
    ev_t act_a [3][64];
    int  act_n [3] = '{0, 0, 0};
    int  err_n [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ns[i] && act_n[i] < 64) begin
                act_a[i][act_n[i]] <= '{cyc, aud_l[i], aud_r[i]};
                act_n[i]           <= act_n[i] + 1;
            end
            if (fe[i]) err_n[i] <= err_n[i] + 1;
        end
    end

    ev_t         exp_a [3][64];
    int          exp_n [3]      = '{0, 0, 0};
    int          exp_base [3]   = '{0, 0, 0};
    int          act_base [3]   = '{0, 0, 0};
    int          err_base [3]   = '{0, 0, 0};
    int          err_exp [3]    = '{0, 0, 0};
    logic [23:0] exp_last_l [3] = '{24'h0, 24'h0, 24'h0};
    logic [23:0] exp_last_r [3] = '{24'h0, 24'h0, 24'h0};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input int inst, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s [dly %0d]: got %0h, expected %0h", nm, dly[inst], got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data bit carried on bclk edge k after the boundary edge for a given delay.
    function automatic logic model_bit(input logic [23:0] l, input logic [23:0] r,
                                       input int k, input int dd);
        int p;
        p = k - dd;
        if (p >= 0 && p < 24) return l[23-p];
        if (p >= 32 && p < 56) return r[23-(p-32)];
        return 1'b0;
    endfunction

    task automatic push_exp(input int i, input int c, input logic [23:0] l,
                            input logic [23:0] r);
        exp_a[i][exp_n[i]] = '{c, l, r};
        exp_n[i]++;
        exp_last_l[i] = l;
        exp_last_r[i] = r;
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int nbits,
                              input int rst_at);
        for (int k = 0; k < nbits; k++) begin
            bclk = 1'b0;
            lr   = (k < 32);
            for (int i = 0; i < 3; i++) d[i] = model_bit(l, r, k, dly[i]);
            if (k == rst_at) begin
                tick(4);
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    exp_last_l[i] = 24'h0;
                    exp_last_r[i] = 24'h0;
                end
                tick(10);
            end else begin
                tick(16);
            end
            bclk = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (rst_at < 0 && k == dly[i] + 55) push_exp(i, cyc + 5, l, r);
            end
            tick(16);
        end
    endtask

    task automatic idle_bits(input int n);
        lr = 1'b0;
        for (int k = 0; k < n; k++) begin
            bclk = 1'b0;
            for (int i = 0; i < 3; i++) d[i] = 1'($urandom);
            tick(16);
            bclk = 1'b1;
            tick(16);
        end
    endtask

    task automatic verify(input string nm);
        for (int i = 0; i < 3; i++) begin
            int na;
            int ne;
            na = act_n[i] - act_base[i];
            ne = exp_n[i] - exp_base[i];
            check({nm, " pulse count"}, i, na, ne);
            for (int j = 0; j < na && j < ne; j++) begin
                check({nm, " pulse cycle"}, i, act_a[i][act_base[i]+j].cyc,
                      exp_a[i][exp_base[i]+j].cyc);
                check({nm, " pulse left"}, i, int'(act_a[i][act_base[i]+j].l),
                      int'(exp_a[i][exp_base[i]+j].l));
                check({nm, " pulse right"}, i, int'(act_a[i][act_base[i]+j].r),
                      int'(exp_a[i][exp_base[i]+j].r));
            end
            check({nm, " held left"}, i, int'(aud_l[i]), int'(exp_last_l[i]));
            check({nm, " held right"}, i, int'(aud_r[i]), int'(exp_last_r[i]));
            act_base[i] = act_n[i];
            exp_base[i] = exp_n[i];
        end
    endtask

    task automatic verify_err(input string nm);
        for (int i = 0; i < 3; i++) begin
            check({nm, " frame_err count"}, i, err_n[i] - err_base[i], err_exp[i]);
            err_base[i] = err_n[i];
            err_exp[i]  = 0;
        end
    endtask

    task automatic mark_err();
        for (int i = 0; i < 3; i++) begin
            err_base[i] = err_n[i];
            err_exp[i]  = 0;
        end
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{24'h111111, 24'h222222, 64, 20, 1'b1};
        tbl[1] = '{24'h7FFFFF, 24'h800000, 64, -1, 1'b1};
        tbl[2] = '{24'h135790, 24'h246801, 64, -1, 1'b1};
        tbl[3] = '{24'hDEADBE, 24'hEFCAFE, 40, -1, 1'b1};
        tbl[4] = '{24'h2468AC, 24'h13579B, 64, -1, 1'b1};
        tbl[5] = '{24'hA5A5A5, 24'h5A5A5A, 64, -1, 1'b1};

        rst  = 1'b1;
        bclk = 1'b0;
        lr   = 1'b0;
        for (int i = 0; i < 3; i++) d[i] = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 3; i++) begin
            check("reset left", i, int'(aud_l[i]), 0);
            check("reset right", i, int'(aud_r[i]), 0);
            check("reset new_sample", i, int'(ns[i]), 0);
            check("reset frame_err", i, int'(fe[i]), 0);
        end
        check("reset bit_cnt", 0, int'(u_dut0.bit_cnt_q), 63);
        check("reset bit_cnt", 1, int'(u_dut1.bit_cnt_q), 63);
        check("reset bit_cnt", 2, int'(u_dut8.bit_cnt_q), 63);

        idle_bits(2);
        mark_err();
        send_frame(24'h123456, 24'hABCDEF, 64, -1);
        verify("single frame");

        for (int n = 1; n <= 10; n++) begin
            logic [23:0] nv;
            nv = 24'(n);
            send_frame(nv, ~nv, 64, -1);
        end
        verify("back-to-back");
        verify_err("back-to-back");

        // Reset mid-frame, then a clean frame; frame_err is not judged across the reset.
        for (int t = 0; t < 2; t++) begin
            send_frame(tbl[t].l, tbl[t].r, tbl[t].nbits, tbl[t].rst_at);
            if (tbl[t].vchk) verify($sformatf("table %0d", t));
        end

        mark_err();
        for (int t = 2; t < 6; t++) begin
            send_frame(tbl[t].l, tbl[t].r, tbl[t].nbits, tbl[t].rst_at);
            for (int i = 0; i < 3; i++) begin
                if (ErrEn && tbl[t].nbits < dly[i] + 56) err_exp[i]++;
            end
            if (tbl[t].vchk) verify($sformatf("table %0d", t));
        end
        verify_err("short frame");

        idle_bits(192);
        verify("long idle");
        check("idle bit_cnt", 0, int'(u_dut0.bit_cnt_q), 63);
        check("idle bit_cnt", 1, int'(u_dut1.bit_cnt_q), 63);
        check("idle bit_cnt", 2, int'(u_dut8.bit_cnt_q), 63);
        verify_err("long idle");

        for (int f = 0; f < 6; f++) begin
            logic [23:0] rl;
            logic [23:0] rr;
            int          nb;
            rl = 24'($urandom);
            rr = 24'($urandom);
            case ($urandom_range(2, 0))
                0:       nb = 40;
                1:       nb = 58;
                default: nb = 64;
            endcase
            if (f == 5) nb = 64;
            send_frame(rl, rr, nb, -1);
            for (int i = 0; i < 3; i++) begin
                if (ErrEn && nb < dly[i] + 56) err_exp[i]++;
            end
        end
        verify("random frames");
        verify_err("random frames");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_data_receiver.md
# i2s_data_receiver

Receive-side companion of the I2S output path: samples the codec's serial ADC line (`i2s_d_in`) using the externally supplied `i2s_bclk`/`i2s_lr`, deserialises one 64-bit stereo frame, and presents 24-bit left/right samples with a one-cycle `new_sample` strobe. Runs entirely in the system `clk` domain, oversampling the codec clocks. It feeds the game's audio-input/level-detect logic and uses the same frame convention as the transmitter: frame starts on `i2s_lr` 0->1; left slot first; 32 bits per slot; 24 data bits MSB-first, then 8 padding bits.

## Interface
- `DATA_DELAY`, default 1: bclk rising edges from the frame-boundary edge to the edge carrying left bit 23. Legal range 0..8.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i2s_bclk` input 1: codec bit clock, asynchronous to `clk`, at most clk/8.
- `i2s_lr` input 1: codec word clock, asynchronous.
- `i2s_d_in` input 1: codec serial data, asynchronous.
- `audio_l_out` output 24: last complete left sample, two's complement.
- `audio_r_out` output 24: last complete right sample.
- `new_sample` output 1: one-`clk` pulse when both outputs have just been updated.
- `frame_err` output 1: one-`clk` pulse on a malformed frame (see Configuration).

## Operation
- `i2s_bclk`, `i2s_lr`, `i2s_d_in` each pass through a 3-flop synchronizer. A one-cycle `bclk_rise` strobe fires when synced bclk goes 0->1. All further logic advances only on `bclk_rise`.
- On `bclk_rise`:
  - shift synced `d_in` into a 64-bit shift register (LSB in);
  - compare synced `lr` with `lr_last`, then update `lr_last`.
- Boundary = `lr` 1 and `lr_last` 0. On a boundary, `bit_cnt` <= 0. Otherwise `bit_cnt` increments and saturates at 63.
- Left capture: when `bit_cnt` becomes `DATA_DELAY+23`, copy `sr[23:0]` into `left_hold`.
- Right capture: when `bit_cnt` becomes `DATA_DELAY+55`, load `audio_r_out` <= `sr[23:0]` and `audio_l_out` <= `left_hold` in the same cycle, and pulse `new_sample`.
- Padding bits are ignored.
- States are implicit in `bit_cnt`:
  - IDLE (63, saturated): no captures;
  - LEFT (0..31);
  - RIGHT (32..62).
  - Any boundary moves to LEFT from any state.
- Short frame: a boundary arriving before right capture discards the partial frame. No `new_sample`; outputs hold their values.
- Long frame: `bit_cnt` saturates in IDLE until the next boundary. Captures are not repeated.

## Timing
- Reset values:
  - `audio_l_out` = 0, `audio_r_out` = 0, `new_sample` = 0, `frame_err` = 0;
  - `bit_cnt` = 63 (IDLE), `lr_last` = 0;
  - synchronizers = 0, shift register = 0.
- Pin to `bclk_rise`: 4 `clk` cycles (3 sync stages + edge detect).
- `new_sample` and the output update occur on the `clk` edge following the `bclk_rise` that completes right capture. Total pin-to-output latency: 5 `clk`.
- `new_sample` is exactly one cycle wide. At most one pulse per frame.
- Reset mid-frame aborts the frame. The first `new_sample` after reset requires a full frame following a fresh `lr` 0->1.
- `rst` has priority over `bclk_rise` in the same cycle.

## Configuration
- `I2S_RX_FRAME_CHECK_EN` defined:
  - `frame_err` pulses for 1 cycle on a boundary arriving with `bit_cnt` < 63 and right capture not yet done (short frame).
  - `frame_err` also pulses on an `lr` 1->0 transition at any `bit_cnt` other than 31 (misaligned half-frame).
  - Capture behaviour is unchanged by the check.
- Not defined: `frame_err` tied to 0; the check logic is not built. The port exists in both builds.

## Structure
- Package `i2s_pkg` holds `SAMPLE_BITS`=24, `SLOT_BITS`=32, `FRAME_BITS`=64 and `CNT_IDLE`=63, shared with the transmitter.
- Sub-module `i2s_pin_sync`: 3-flop synchronizer for the three pins, plus the `bclk_rise` strobe. It is reusable by the transmitter.
- Top module holds the shift register, counter, hold register and outputs.

## Test plan
- Bench setup for all scenarios: `clk` 100 MHz, bclk = clk/32, 64 bclk/frame. The bench model drives `d_in` per `DATA_DELAY`.
- Frame L=0x123456, R=0xABCDEF, `DATA_DELAY`=1 -> one `new_sample`; outputs 0x123456/0xABCDEF exactly 5 clk after the 56th post-boundary bclk rise.
- Ten back-to-back frames of incrementing values (L=n, R=~n) -> ten pulses, each matching its frame, no drops.
- Reset asserted at bit 20 of a frame -> outputs 0, no pulse for that frame; the next full frame (L=0x7FFFFF, R=0x800000) is captured correctly.
- Frame cut short (`lr` rises again after 40 bits) -> no `new_sample`, outputs hold previous values; with `I2S_RX_FRAME_CHECK_EN`, one `frame_err` pulse.
- `DATA_DELAY`=0 and =8 with L=0xA5A5A5, R=0x5A5A5A -> correct capture in both cases.
- `lr` held low for 3 frame periods -> no pulses, `bit_cnt` stays 63.
